// File: rtl/argmax_stream_classifier.sv
// argmax_stream_classifier: streaming argmax over NUM_CLASSES score beats, reporting the
// winning class, its score, the margin to the runner-up, low confidence and framing errors.
module argmax_stream_classifier #(
  parameter int          NUM_CLASSES = 10,
  parameter int          SCORE_W     = 113,
  parameter bit          SIGNED_CMP  = 1'b1,
  parameter int unsigned MARGIN_TH   = 0,
  parameter int          IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SCORE_W-1:0] s_score,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [IDX_W-1:0]   m_class,
  output logic [SCORE_W-1:0] m_max,
  output logic [SCORE_W:0]   m_margin,
  output logic               m_low_conf,
  output logic               m_err,
  output logic [15:0]        frame_cnt
);
  typedef enum logic {ACC, HOLD} state_t;
  localparam logic [SCORE_W-1:0] MIN_SCORE = SIGNED_CMP ? {1'b1, {(SCORE_W-1){1'b0}}} : '0;
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx, r_best_idx, w_nidx;
  logic [SCORE_W-1:0] r_best, r_second, w_nbest, w_nsec;
  logic [SCORE_W:0] w_margin;
  logic w_beat, w_ack, w_first, w_last_idx, w_close, w_take;

  function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    return SIGNED_CMP ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  assign s_ready    = (r_state == ACC) & rst_n;
  assign m_valid    = r_state == HOLD;
  assign w_beat     = s_valid & s_ready & ~clear;
  assign w_ack      = m_valid & m_ready & ~clear;
  assign w_first    = r_idx == '0;
  assign w_last_idx = r_idx == IDX_W'(NUM_CLASSES - 1);
  assign w_close    = w_beat & (s_last | w_last_idx);
  // Strict compare keeps the earliest index on ties.
  assign w_take     = w_first | gt(s_score, r_best);
  assign w_nbest    = w_take ? s_score : r_best;
  assign w_nidx     = w_take ? r_idx : r_best_idx;
  assign w_nsec     = w_first ? MIN_SCORE : w_take ? r_best : gt(s_score, r_second) ? s_score : r_second;
  // One extra bit so best - second cannot overflow; a single-beat frame has no runner-up.
  assign w_margin   = w_first ? '1 : {SIGNED_CMP & w_nbest[SCORE_W-1], w_nbest}
                                   - {SIGNED_CMP & w_nsec[SCORE_W-1], w_nsec};

  always_comb w_next = clear ? ACC : w_close ? HOLD : w_ack ? ACC : r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best     <= '0;
      r_second   <= '0;
      m_class    <= '0;
      m_max      <= '0;
      m_margin   <= '0;
      m_low_conf <= 1'b0;
      m_err      <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (clear) r_idx <= '0;
      else if (w_beat) begin
        r_idx      <= w_close ? '0 : r_idx + 1'b1;
        r_best     <= w_nbest;
        r_second   <= w_nsec;
        r_best_idx <= w_nidx;
      end
      if (w_close) begin
        m_class    <= w_nidx;
        m_max      <= w_nbest;
        m_margin   <= w_margin;
        m_low_conf <= w_margin <= (SCORE_W + 1)'(MARGIN_TH);
        m_err      <= ~(s_last & w_last_idx);
      end
      if (w_ack) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_argmax_stream_classifier.sv
// tb_argmax_stream_classifier: queue-based reference model with per-cycle compare, directed
// literal scenarios, randomized frames, and an unsigned 8-bit instance for threshold/reset.
module tb_argmax_stream_classifier;
  localparam int NC = 10;
  localparam int SW = 113;
  typedef logic [SW-1:0] sc_t;
  typedef struct packed {
    logic [3:0] cls;
    sc_t        mx;
    logic [SW:0] mg;
    logic       lc;
    logic       err;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  sc_t s_score = '0;
  logic s_ready, m_valid, m_low_conf, m_err;
  logic [3:0] m_class;
  sc_t m_max;
  logic [SW:0] m_margin;
  logic [15:0] frame_cnt;

  logic u_rst_n = 1'b0, u_valid = 1'b0, u_last = 1'b0, u_mready = 1'b0;
  logic [7:0] u_score = '0;
  logic u_sready, u_mvalid, u_lc, u_err;
  logic [3:0] u_class;
  logic [7:0] u_max;
  logic [8:0] u_margin;
  logic [15:0] u_cnt;

  int checks = 0, errors = 0;
  int fv[$];

  argmax_stream_classifier dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_score(s_score), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_max(m_max), .m_margin(m_margin), .m_low_conf(m_low_conf),
    .m_err(m_err), .frame_cnt(frame_cnt)
  );

  argmax_stream_classifier #(.SCORE_W(8), .SIGNED_CMP(1'b0), .MARGIN_TH(10)) dut_u (
    .clk(clk), .rst_n(u_rst_n), .clear(1'b0), .s_valid(u_valid), .s_ready(u_sready),
    .s_score(u_score), .s_last(u_last), .m_valid(u_mvalid), .m_ready(u_mready),
    .m_class(u_class), .m_max(u_max), .m_margin(u_margin), .m_low_conf(u_lc),
    .m_err(u_err), .frame_cnt(u_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner is the first maximum; runner-up is the largest of all other received scores.
  function automatic res_t predict(input sc_t fq[$], input logic last);
    res_t r;
    int b = 0;
    logic signed [SW:0] top, sec, v;
    logic found = 1'b0;
    for (int i = 1; i < fq.size(); i++) if ($signed(fq[i]) > $signed(fq[b])) b = i;
    top = {fq[b][SW-1], fq[b]};
    sec = '0;
    for (int j = 0; j < fq.size(); j++) begin
      v = {fq[j][SW-1], fq[j]};
      if (j != b && (!found || v > sec)) begin
        sec = v;
        found = 1'b1;
      end
    end
    r.cls = 4'(b);
    r.mx  = fq[b];
    r.mg  = found ? top - sec : '1;
    r.lc  = r.mg <= '0;
    r.err = !(last && fq.size() == NC);
    return r;
  endfunction

  sc_t q[$];
  logic hold = 1'b0;
  logic [15:0] cnt = '0;
  res_t exp_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 1'b0;
      cnt <= '0;
      q.delete();
    end else if (clear) begin
      hold <= 1'b0;
      q.delete();
    end else if (hold) begin
      if (m_ready) begin
        hold <= 1'b0;
        cnt <= cnt + 16'd1;
      end
    end else if (s_valid) begin
      q.push_back(s_score);
      if (s_last || q.size() == NC) begin
        exp_r <= predict(q, s_last);
        hold <= 1'b1;
        q.delete();
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("m_valid", 128'(m_valid), 128'(hold));
    chk("s_ready", 128'(s_ready), 128'(!hold));
    chk("frame_cnt", 128'(frame_cnt), 128'(cnt));
    if (hold) begin
      chk("m_class", 128'(m_class), 128'(exp_r.cls));
      chk("m_max", 128'(m_max), 128'(exp_r.mx));
      chk("m_margin", 128'(m_margin), 128'(exp_r.mg));
      chk("m_low_conf", 128'(m_low_conf), 128'(exp_r.lc));
      chk("m_err", 128'(m_err), 128'(exp_r.err));
    end
  end

  function automatic sc_t rnd_score();
    logic [127:0] w = {$urandom(), $urandom(), $urandom(), $urandom()};
    int v = int'($urandom_range(0, 6)) - 3;
    return $urandom_range(0, 2) == 0 ? w[SW-1:0] : sc_t'(v);
  endfunction

  task automatic send(input sc_t sc, input logic last);
    int t = 0;
    s_valid = 1'b1;
    s_score = sc;
    s_last = last;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("send_timeout", 128'(s_ready), 128'(1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(input logic use_last);
    foreach (fv[i]) send(sc_t'(fv[i]), use_last && i == fv.size() - 1);
  endtask

  task automatic wait_res(input int hold_cycles, input logic do_clear);
    int t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("result_timeout", 128'(m_valid), 128'(1));
    repeat (hold_cycles) @(negedge clk);
    m_ready = 1'b1;
    clear = do_clear;
    @(negedge clk);
    m_ready = 1'b0;
    clear = 1'b0;
  endtask

  task automatic pulse_clear();
    s_valid = 1'($urandom_range(0, 1));
    s_score = rnd_score();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int len, cl;
    logic nolast;
    repeat (2) @(negedge clk);
    chk("rst m_valid", 128'(m_valid), 128'(0));
    chk("rst s_ready", 128'(s_ready), 128'(0));
    chk("rst frame_cnt", 128'(frame_cnt), 128'(0));
    chk("rst m_margin", 128'(m_margin), 128'(0));
    #2 rst_n = 1'b1;
    u_rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst s_ready", 128'(s_ready), 128'(1));

    fv = '{5, -3, 9, 9, 2, 0, 1, -7, 4, 8};
    send_frame(1'b1);
    chk("t1 class", 128'(m_class), 128'(2));
    chk("t1 max", 128'(m_max), 128'(sc_t'(9)));
    chk("t1 margin", 128'(m_margin), 128'(0));
    chk("t1 low_conf", 128'(m_low_conf), 128'(1));
    chk("t1 err", 128'(m_err), 128'(0));
    wait_res(0, 1'b0);
    chk("t1 frame_cnt", 128'(frame_cnt), 128'(1));

    fv = '{-100, -100, -100, -100, -100, -100, -100, -100, -100, -100};
    send_frame(1'b1);
    chk("t2 class", 128'(m_class), 128'(0));
    chk("t2 max", 128'(m_max), 128'(sc_t'(-100)));
    chk("t2 margin", 128'(m_margin), 128'(0));
    wait_res(1, 1'b0);
    fv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(1'b1);
    chk("t2 asc class", 128'(m_class), 128'(9));
    chk("t2 asc margin", 128'(m_margin), 128'(1));
    wait_res(0, 1'b0);
    chk("t2 frame_cnt", 128'(frame_cnt), 128'(3));

    fv = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(1'b1);
    repeat (20) @(negedge clk);
    chk("t3 held valid", 128'(m_valid), 128'(1));
    chk("t3 held s_ready", 128'(s_ready), 128'(0));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t3 s_ready after ack", 128'(s_ready), 128'(1));

    fv = '{1, 7, 2, 3};
    send_frame(1'b1);
    chk("t4 short class", 128'(m_class), 128'(1));
    chk("t4 short margin", 128'(m_margin), 128'(4));
    chk("t4 short err", 128'(m_err), 128'(1));
    wait_res(0, 1'b0);
    fv = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    send_frame(1'b0);
    chk("t4 nolast valid", 128'(m_valid), 128'(1));
    chk("t4 nolast err", 128'(m_err), 128'(1));
    wait_res(0, 1'b0);

    fv = '{1000, 1000, 1000, 1000};
    send_frame(1'b0);
    s_valid = 1'b1;
    s_score = sc_t'(5000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    s_valid = 1'b0;
    fv = '{-1, -2, 3, -4, 0, 2, -5, 1, -6, -7};
    send_frame(1'b1);
    chk("t5 class", 128'(m_class), 128'(2));
    chk("t5 max", 128'(m_max), 128'(sc_t'(3)));
    chk("t5 margin", 128'(m_margin), 128'(1));
    wait_res(0, 1'b0);
    send_frame(1'b1);
    wait_res(2, 1'b1);
    chk("t5 clear-hold valid", 128'(m_valid), 128'(0));
    chk("t5 clear-hold cnt", 128'(frame_cnt), 128'(7));

    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, NC);
      nolast = len == NC && $urandom_range(0, 1) == 1;
      cl = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len && i != cl; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        send(rnd_score(), !nolast && i == len - 1);
      end
      if (cl >= 0) pulse_clear();
      else wait_res($urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    fv = '{200, 250, 245, 10, 20, 30, 40, 50, 60, 70};
    foreach (fv[i]) begin
      u_valid = 1'b1;
      u_score = 8'(fv[i]);
      u_last = i == NC - 1;
      @(negedge clk);
    end
    u_valid = 1'b0;
    u_last = 1'b0;
    chk("t6 valid", 128'(u_mvalid), 128'(1));
    chk("t6 class", 128'(u_class), 128'(1));
    chk("t6 max", 128'(u_max), 128'(250));
    chk("t6 margin", 128'(u_margin), 128'(5));
    chk("t6 low_conf", 128'(u_lc), 128'(1));
    chk("t6 err", 128'(u_err), 128'(0));
    u_mready = 1'b1;
    @(negedge clk);
    u_mready = 1'b0;
    chk("t6 cnt", 128'(u_cnt), 128'(1));
    for (int i = 0; i < 3; i++) begin
      u_valid = 1'b1;
      u_score = 8'(10 * i + 1);
      @(negedge clk);
    end
    u_valid = 1'b0;
    #2 u_rst_n = 1'b0;
    #1;
    chk("t6 rst class", 128'(u_class), 128'(0));
    chk("t6 rst max", 128'(u_max), 128'(0));
    chk("t6 rst margin", 128'(u_margin), 128'(0));
    chk("t6 rst cnt", 128'(u_cnt), 128'(0));
    chk("t6 rst s_ready", 128'(u_sready), 128'(0));
    #1 u_rst_n = 1'b1;
    @(negedge clk);
    chk("t6 post-rst s_ready", 128'(u_sready), 128'(1));
    for (int i = 0; i < NC; i++) begin
      u_valid = 1'b1;
      u_score = 8'(i);
      u_last = i == NC - 1;
      @(negedge clk);
    end
    u_valid = 1'b0;
    u_last = 1'b0;
    chk("t6 fresh class", 128'(u_class), 128'(9));
    chk("t6 fresh margin", 128'(u_margin), 128'(1));
    chk("t6 fresh err", 128'(u_err), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
